alu_issue_wb: RTL
=================

ALU_ISSUE_WB -- requirements
Module: alu_issue_wb

Interface
- REQ-001: Parameter REG_COUNT, default 16, is the number of 32-bit architectural registers; register 0 is hardwired to zero.
- REQ-002: Parameter IMM_WIDTH, default 16, is the immediate field width; the immediate is sign-extended to 32 bits.
- REQ-003: clk  in  1  single clock; all state updates on the rising edge.
- REQ-004: rst_n  in  1  reset, asynchronous, active-low.
- REQ-005: in_valid  in  1  an instruction is presented.
- REQ-006: in_ready  out  1  the block accepts the instruction this cycle.
- REQ-007: in_funct  in  4  ALU operation code, legal 4'h0..4'h8.
- REQ-008: in_rd, in_rs, in_rt  in  4 each  destination register, A-source register and B-source register.
- REQ-009: in_use_imm  in  1  when 1, the B operand is the sign-extended in_imm instead of reg[in_rt].
- REQ-010: in_imm  in  IMM_WIDTH  immediate value.
- REQ-011: alu_a, alu_b  out  32 each  registered operands to the downstream combinational ALU.
- REQ-012: alu_funct  out  4  registered ALU operation code.
- REQ-013: alu_out  in  32  ALU result, combinational from alu_a, alu_b and alu_funct.
- REQ-014: alu_flagZ  in  1  ALU zero flag.
- REQ-015: wb_valid  out  1  a write-back completed on the previous edge.
- REQ-016: wb_rd  out  4  destination register of that write-back.
- REQ-017: wb_data  out  32  data written by that write-back.
- REQ-018: flag_z  out  1  zero flag of the most recent completed operation.
- REQ-019: err  out  1  an illegal funct was received.
- REQ-020: clr_err  in  1  single-cycle pulse that clears err and resumes operation.

Function
- REQ-021: An instruction is accepted on a rising edge where in_valid=1 and in_ready=1.
- REQ-022: The FSM has two states: RUN and HALT. In_ready=1 in RUN and in_ready=0 in HALT.
- REQ-023: A legal instruction accepted at edge N loads the EX register, ex_valid=1, alu_a, alu_b, alu_funct and ex_rd, and drives them throughout cycle N+1.
- REQ-024: At edge N+1 the EX instruction completes:
  - reg[ex_rd] <= alu_out, unless ex_rd=0;
  - wb_valid=1, wb_rd=ex_rd, wb_data=alu_out and flag_z=alu_flagZ are captured and held for one cycle.
- REQ-025: A completion with ex_rd=0 still asserts wb_valid with wb_data=alu_out, but no register changes.
- REQ-026: Operands are resolved at the accept edge with the following priority:
  - source index 0 gives 0;
  - else, if ex_valid=1 and ex_rd equals the source index, the current alu_out (forwarding);
  - else reg[source].
- REQ-027: Back-to-back dependent instructions issue at full throughput with no bubbles; latency from accept to wb_valid is 2 cycles.
- REQ-028: When no instruction is accepted at an edge, ex_valid is cleared at that edge; alu_a, alu_b and alu_funct hold their last values.
- REQ-029: An illegal funct (4'h9..4'hF) accepted in RUN is not issued to EX. At the accept edge, err<=1 and the FSM moves to HALT.
- REQ-030: An instruction already in EX when an illegal funct is accepted still completes normally.
- REQ-031: In HALT, a clr_err=1 at an edge clears err and returns the FSM to RUN; no instruction is accepted at that edge.
- REQ-032: clr_err in RUN has no effect.
- REQ-033: No register file write occurs other than through EX completion.

Reset
- REQ-034: While rst_n=0, immediately and independently of clk:
  - all registers are 0 and ex_valid=0;
  - alu_a=0, alu_b=0, alu_funct=0;
  - wb_valid=0, wb_rd=0, wb_data=0;
  - flag_z=0, err=0;
  - the FSM is in RUN.
- REQ-035: Reset asserted mid-operation discards the EX instruction with no write-back. The first edge with rst_n=1 may accept an instruction.

Verification
- REQ-036: Scenario immediate add: ADD r1=r0+imm 5, then (ADD) r2=r1+imm -3 on consecutive cycles -> wb_data 5 and then 2. r2=2 is obtained via forwarding, and flag_z=0.
- REQ-037: Scenario subtract to zero: r3=7, then SUB r4=r3-r3 -> wb_data=0, flag_z=1 and wb_rd=4.
- REQ-038: Scenario write to r0: ADD r0=r0+imm 9 -> wb_valid=1 and wb_data=9, and a subsequent read of r0 yields 0.
- REQ-039: Scenario illegal funct: funct 4'hA issued right after a legal op -> the legal op writes back, err=1 and in_ready=0 for 3 idle cycles. A clr_err pulse then gives err=0 and in_ready=1 on the next cycle.
- REQ-040: Scenario reset mid-pipe: rst_n dropped while ex_valid=1 -> no wb_valid, all outputs are 0 immediately, and r1..r15 read back 0.
- REQ-041: Scenario shift: r5=32'h80000000, SRA by imm 4 -> wb_data 32'hF8000000.

Source files
------------

// File: rtl/alu_issue_wb.sv
// alu_issue_wb
//   Single-issue front end for an external combinational ALU. Instructions are
//   accepted into an EX register, where operands are resolved with
//   forwarding. They complete one edge later, writing alu_out back into the
//   register file. An illegal funct halts issue until clr_err is pulsed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready instruction handshake (ready only in RUN)
//   in_funct          ALU operation code, legal 4'h0..4'h8
//   in_rd/rs/rt       destination, A-source, B-source register indices
//   in_use_imm/in_imm B operand select / immediate (sign-extended)
//   alu_a/b/funct     registered operands and opcode to the external ALU
//   alu_out/alu_flagZ combinational ALU result and zero flag
//   wb_valid/rd/data  write-back completed on the previous edge
//   flag_z            zero flag of the most recent completed operation
//   err, clr_err      illegal-funct error flag and its clear pulse
module alu_issue_wb #(
    parameter int unsigned REG_COUNT = 16,
    parameter int unsigned IMM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_funct,
    input  logic [3:0]           in_rd,
    input  logic [3:0]           in_rs,
    input  logic [3:0]           in_rt,
    input  logic                 in_use_imm,
    input  logic [IMM_WIDTH-1:0] in_imm,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [3:0]           alu_funct,
    input  logic [31:0]          alu_out,
    input  logic                 alu_flagZ,
    output logic                 wb_valid,
    output logic [3:0]           wb_rd,
    output logic [31:0]          wb_data,
    output logic                 flag_z,
    output logic                 err,
    input  logic                 clr_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        err_q, err_d;
    logic        ex_valid_q, ex_valid_d;
    logic [3:0]  ex_rd_q, ex_rd_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [3:0]  alu_funct_q, alu_funct_d;
    logic        wb_valid_q, wb_valid_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        flag_z_q, flag_z_d;
    logic [31:0] regs_q [REG_COUNT];
    logic [31:0] regs_d [REG_COUNT];

    logic        accept;
    logic        legal;
    logic [31:0] op_a;
    logic [31:0] op_b_reg;
    logic [31:0] imm_ext;

    assign in_ready = (state_q == RUN);
    assign accept   = in_valid && in_ready;
    assign legal    = (in_funct <= 4'h8);
    assign imm_ext  = 32'(signed'(in_imm));

    // Operand resolution: r0 reads zero, then the in-flight EX result wins
    // over the stale register file copy so dependent ops issue without bubbles.
    always_comb begin
        op_a = '0;
        if (in_rs == 4'd0) begin
            op_a = '0;
        end else if (ex_valid_q && (ex_rd_q == in_rs)) begin
            op_a = alu_out;
        end else if (32'(in_rs) < REG_COUNT) begin
            op_a = regs_q[in_rs];
        end
    end

    always_comb begin
        op_b_reg = '0;
        if (in_rt == 4'd0) begin
            op_b_reg = '0;
        end else if (ex_valid_q && (ex_rd_q == in_rt)) begin
            op_b_reg = alu_out;
        end else if (32'(in_rt) < REG_COUNT) begin
            op_b_reg = regs_q[in_rt];
        end
    end

    always_comb begin
        state_d     = state_q;
        err_d       = err_q;
        ex_valid_d  = 1'b0;
        ex_rd_d     = ex_rd_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_funct_d = alu_funct_q;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        flag_z_d    = flag_z_q;
        regs_d      = regs_q;

        // EX completion is independent of the FSM, so an op already in EX
        // still retires on the edge that accepts an illegal funct.
        if (ex_valid_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_q;
            wb_data_d  = alu_out;
            flag_z_d   = alu_flagZ;
            if ((ex_rd_q != 4'd0) && (32'(ex_rd_q) < REG_COUNT)) begin
                regs_d[ex_rd_q] = alu_out;
            end
        end

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (legal) begin
                        ex_valid_d  = 1'b1;
                        ex_rd_d     = in_rd;
                        alu_a_d     = op_a;
                        alu_b_d     = in_use_imm ? imm_ext : op_b_reg;
                        alu_funct_d = in_funct;
                    end else begin
                        err_d   = 1'b1;
                        state_d = HALT;
                    end
                end
            end
            HALT: begin
                if (clr_err) begin
                    err_d   = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            err_q       <= 1'b0;
            ex_valid_q  <= 1'b0;
            ex_rd_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_funct_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            flag_z_q    <= 1'b0;
            for (int unsigned i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            ex_valid_q  <= ex_valid_d;
            ex_rd_q     <= ex_rd_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_funct_q <= alu_funct_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            flag_z_q    <= flag_z_d;
            regs_q      <= regs_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_funct = alu_funct_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign flag_z    = flag_z_q;
    assign err       = err_q;

endmodule
